hex_counter_display: RTL

//  Parametrised multi-digit up/down counter with seven-segment and LED readout.
//  - Steps once per debounced-free rising edge of a pushbutton-level input.
//  - Can be loaded from the switches, counts in hex or BCD, flags wrap-around.
//  - Sits under a board-level top: KEY/SW in, HEXn/LEDR out. The top inverts the

---
 rtl/hex_counter_display.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/hex_counter_display.sv
// Multi-digit hex/BCD up/down counter stepped by a synchronised pushbutton level,
// with registered seven-segment and LED readout. Define LEADING_ZERO_BLANK_EN to blank leading zeros.
module hex_counter_display #(
    parameter int DIGITS = 2,
    parameter int BCD    = 0,
    parameter int LED_W  = 10
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Step,
    input  logic                  Load,
    input  logic                  Up,
    input  logic [4*DIGITS-1:0]   Data,
    output logic [7*DIGITS-1:0]   HEX,
    output logic [LED_W-1:0]      LEDR,
    output logic                  Wrap
);

    localparam int CW = 4 * DIGITS;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    logic          s1, s2, d;
    logic          armed;
    logic [1:0]    fill;
    logic          step_edge;
    logic [CW-1:0] count;
    logic [CW-1:0] stepped;
    logic          step_wrap;
    logic [CW-1:0] load_val;
    logic          wrap_q;
    logic [7*DIGITS-1:0] hex_next;

    // armed waits until s2 carries a real sample, so a Step held through reset never counts
    assign step_edge = s2 & ~d & armed;

    // NOTE: every variable assigned in a combinational block gets a default first so no latch is inferred.
    always_comb begin : next_count
        logic [3:0] dg;
        logic       carry;
        stepped   = count;
        step_wrap = 1'b0;
        carry     = 1'b1;
        dg        = 4'd0;
        if (BCD != 0) begin
            for (int i = 0; i < DIGITS; i++) begin
                dg = count[4*i +: 4];
                if (carry) begin
                    if (Up) begin
                        if (dg >= 4'd9) dg = 4'd0;
                        else begin dg = dg + 4'd1; carry = 1'b0; end
                    end else begin
                        if (dg == 4'd0) dg = 4'd9;
                        else begin dg = dg - 4'd1; carry = 1'b0; end
                    end
                end
                stepped[4*i +: 4] = dg;
            end
            step_wrap = carry;
        end else if (Up) begin
            stepped   = count + CW'(1);
            step_wrap = &count;
        end else begin
            stepped   = count - CW'(1);
            step_wrap = ~|count;
        end
    end

    always_comb begin : clamp_load
        load_val = Data;
        if (BCD != 0) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (Data[4*i +: 4] > 4'd9) load_val[4*i +: 4] = 4'd9;
            end
        end
    end

    always_comb begin : decode
        logic [3:0] dg;
`ifdef LEADING_ZERO_BLANK_EN
        logic seen;
        seen = 1'b0;
`endif
        hex_next = '0;
        dg       = 4'd0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            dg = count[4*i +: 4];
            hex_next[7*i +: 7] = seg7(dg);
`ifdef LEADING_ZERO_BLANK_EN
            if (dg != 4'd0) seen = 1'b1;
            else if (!seen && i != 0) hex_next[7*i +: 7] = 7'b1111111;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments; the synchronous reset clears every flop.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            d      <= 1'b0;
            fill   <= 2'b00;
            armed  <= 1'b0;
            count  <= '0;
            wrap_q <= 1'b0;
            Wrap   <= 1'b0;
            HEX    <= {DIGITS{7'b1000000}};
            LEDR   <= '0;
        end else begin
            s1     <= Step;
            s2     <= s1;
            d      <= s2;
            fill   <= {fill[0], 1'b1};
            armed  <= armed | (fill[1] & ~s2);
            wrap_q <= 1'b0;
            if (Load) begin
                count <= load_val;
            end else if (step_edge) begin
                count  <= stepped;
                wrap_q <= step_wrap;
            end
            // Wrap is delayed one stage so it lines up with the HEX/LEDR refresh
            Wrap <= wrap_q;
            HEX  <= hex_next;
            LEDR <= LED_W'(count);
        end
    end

endmodule
